registro_barcos: RTL and testbench
==================================

# registro_barcos

Ship-status register bank for the battleship game datapath. It holds one 5-bit segment mask per ship, where a set bit means that segment is afloat. On a `setter` rising edge it clears the bank and then loads the default fleet, one ship per clock. Downstream hit and display logic reads `barcos` combinationally every cycle.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- Parameters:
  - `numBarcos`, default 5: number of ships, which is also the number of entries in `barcos`. Legal range 1..32.
- Ports:
  - `clk`, input, 1 bit: system clock. All state updates on the rising edge.
  - `rst`, input, 1 bit: asynchronous, active-low reset. `rst`=0 clears all state immediately.
  - `setter`, input, 1 bit: load request. Synchronous and level-sampled; acted on only at its rising edge.
  - `barcos`, output, unpacked array `[0:numBarcos-1]` of 5 bits: per-ship segment mask. Bit j=1 means segment j of ship i is afloat. Driven directly from registers.

## Operation
- Internal state:
  - `setter_q`: 1-bit registered copy of `setter`.
  - `idx`: load index, wide enough for 0..numBarcos-1.
  - FSM with states IDLE, LOAD, DONE.
  - Storage for `barcos`.
- Start condition: `start` = `setter` & ~`setter_q`, evaluated at each rising `clk`.
- Default mask for ship k: `mask(k)` = (1 << min(k+1,5)) - 1, i.e. ship length is k+1, saturating at 5.
  - Ship 0 = 5'b00001
  - Ship 1 = 5'b00011
  - Ship 2 = 5'b00111
  - Ship 3 = 5'b01111
  - Ship 4 and above = 5'b11111
- IDLE:
  - If `start`: clear every `barcos` entry to 0, set `idx`=0, go to LOAD.
  - Otherwise hold.
- LOAD:
  - Each edge: `barcos[idx]` <= `mask(idx)`, `idx` <= `idx`+1.
  - When the entry written is the last one (`idx` = numBarcos-1): go to DONE; `idx` returns to 0.
  - `start` is ignored while in LOAD. The load is not restartable mid-sequence.
- DONE:
  - Entries hold their values.
  - If `start`: same action as from IDLE (clear all, `idx`=0, go to LOAD).
- Entries not yet written during a LOAD read 0.
- No other writes to `barcos` exist in this block.

## Timing
- Reset (`rst`=0, asynchronous):
  - All `barcos` entries = 5'b00000.
  - `setter_q`=0, `idx`=0, state IDLE.
  - Takes effect without waiting for a clock and overrides any in-progress LOAD.
- Reset release: the first rising edge with `rst`=1 is a normal operating edge.
  - `setter` already high at release counts as a rising edge, because `setter_q` resets to 0.
- Load latency: let edge N be the edge where `start` is detected.
  - Edge N: all entries become 0.
  - Edge N+1+k: entry k becomes `mask(k)`.
  - Edge N+numBarcos: last entry written, state becomes DONE.
  - Total load takes numBarcos+1 edges including the clear.
- Retrigger: a `setter` rising edge during LOAD is lost. The caller must re-pulse after DONE.
- Holding `setter` high generates exactly one start.
- Output changes only at rising `clk` or at assertion of `rst`. No combinational path from `setter` to `barcos`.

## Test plan
- Reset: drive `rst`=0 with `setter`=0 and toggle `clk` → all five entries read 0, both during reset and after release while `setter` stays low for 10 cycles.
- Basic load (numBarcos=5): raise `setter` for one cycle → entries fill one per edge. Final values 1, 3, 7, 15, 31 after 6 edges; values hold 20 further cycles.
- Held `setter` plus retrigger during LOAD: hold `setter` high 50 cycles → exactly one load. Pulse `setter` again while `idx`=2 → sequence completes unchanged with no restart.
- Reload from DONE: after a completed load, pulse `setter` → at the next edge all entries read 0, then the same 1, 3, 7, 15, 31 sequence refills.
- Asynchronous reset mid-load: assert `rst`=0 between clock edges while `idx`=3 → entries read 0 immediately. After release, no load occurs until a new `setter` edge.
- Parameter sweep: numBarcos=7 → entries 5 and 6 read 31 and the load spans 8 edges. numBarcos=1 → the single entry reads 1 after 2 edges.

Source files
------------

// File: rtl/registro_barcos.sv
// Ship-status register bank: one 5-bit afloat mask per ship. A rising edge on
// setter clears the bank, then loads the default fleet one ship per clock.
module registro_barcos #(
  parameter int unsigned numBarcos = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setter,
  output logic [4:0] barcos [0:numBarcos-1]
);

  localparam int unsigned IdxW = (numBarcos > 1) ? $clog2(numBarcos) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(numBarcos - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            setter_q;
  logic            start;
  logic            clear_all;
  logic            load_en;
  logic [4:0]      barcos_q [0:numBarcos-1];

  // Ship k is k+1 segments long, saturating at a full 5-segment hull.
  function automatic logic [4:0] mask_of(input int unsigned k);
    if (k >= 4) begin
      return 5'b11111;
    end
    return 5'((32'd1 << (k + 1)) - 32'd1);
  endfunction

  assign start = setter & ~setter_q;

  // Next-state and bank control; start is only honoured outside LOAD.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clear_all = 1'b0;
    load_en   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          clear_all = 1'b1;
          idx_d     = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        load_en = 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, edge detector and ship bank; reset wipes everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      setter_q <= 1'b0;
      for (int i = 0; i < int'(numBarcos); i++) begin
        barcos_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      setter_q <= setter;
      if (clear_all) begin
        for (int i = 0; i < int'(numBarcos); i++) begin
          barcos_q[i] <= '0;
        end
      end else if (load_en) begin
        barcos_q[idx_q] <= mask_of(int'(idx_q));
      end
    end
  end

  assign barcos = barcos_q;

endmodule

// File: tb/tb_registro_barcos.sv
// Directed bench for registro_barcos: 5-, 7- and 1-ship instances.
module tb_registro_barcos;

  logic       clk;
  logic       rst;
  logic       setter5;
  logic       setterx;
  logic [4:0] b5 [0:4];
  logic [4:0] b7 [0:6];
  logic [4:0] b1 [0:0];

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed default fleet masks for ships 0..6.
  logic [4:0] tbl [0:6] = '{5'd1, 5'd3, 5'd7, 5'd15, 5'd31, 5'd31, 5'd31};

  registro_barcos #(.numBarcos(5)) u_dut5 (
    .clk    (clk),
    .rst    (rst),
    .setter (setter5),
    .barcos (b5)
  );

  registro_barcos #(.numBarcos(7)) u_dut7 (
    .clk    (clk),
    .rst    (rst),
    .setter (setterx),
    .barcos (b7)
  );

  registro_barcos #(.numBarcos(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .setter (setterx),
    .barcos (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] got5();
    logic [63:0] r = '0;
    for (int i = 0; i < 5; i++) r[5*i +: 5] = b5[i];
    return r;
  endfunction

  function automatic logic [63:0] got7();
    logic [63:0] r = '0;
    for (int i = 0; i < 7; i++) r[5*i +: 5] = b7[i];
    return r;
  endfunction

  function automatic logic [63:0] got1();
    logic [63:0] r = '0;
    r[4:0] = b1[0];
    return r;
  endfunction

  // Expected bank of n ships with the first k entries loaded, the rest zero.
  function automatic logic [63:0] exp_prefix(input int n, input int k);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) begin
      if (i < k) r[5*i +: 5] = tbl[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    setter5 = 1'b0;
    setterx = 1'b0;

    // Reset held while clock runs.
    repeat (3) tick();
    check_eq("rst_hold5", got5(), '0);
    check_eq("rst_hold7", got7(), '0);
    check_eq("rst_hold1", got1(), '0);
    #2 rst = 1'b1;
    repeat (10) tick();
    check_eq("idle_after_rst", got5(), '0);

    // Basic one-cycle pulse.
    setter5 = 1'b1;
    tick();
    check_eq("basic_clr", got5(), '0);
    setter5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq($sformatf("basic_k%0d", k), got5(), exp_prefix(5, k));
    end
    repeat (20) tick();
    check_eq("basic_hold", got5(), exp_prefix(5, 5));
    check_eq("basic_others7", got7(), '0);

    // Reload from DONE with a retrigger pulse while idx=2.
    setter5 = 1'b1;
    tick();
    check_eq("reload_clr", got5(), '0);
    setter5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) setter5 = 1'b1;
      tick();
      setter5 = 1'b0;
      check_eq($sformatf("reload_k%0d", k), got5(), exp_prefix(5, k));
    end
    repeat (20) tick();
    check_eq("retrig_no_restart", got5(), exp_prefix(5, 5));

    // Setter held high for 50 cycles gives exactly one load.
    setter5 = 1'b1;
    tick();
    check_eq("held_clr", got5(), '0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq($sformatf("held_k%0d", k), got5(), exp_prefix(5, k));
    end
    repeat (44) tick();
    check_eq("held_once", got5(), exp_prefix(5, 5));
    setter5 = 1'b0;
    tick();
    check_eq("held_release", got5(), exp_prefix(5, 5));

    // Asynchronous reset in the middle of a load (idx=3).
    setter5 = 1'b1;
    tick();
    setter5 = 1'b0;
    repeat (3) tick();
    check_eq("async_pre", got5(), exp_prefix(5, 3));
    #2 rst = 1'b0;
    #1;
    check_eq("async_immediate", got5(), '0);
    tick();
    #2 rst = 1'b1;
    repeat (10) tick();
    check_eq("async_no_load", got5(), '0);

    // Parameter sweep: 7 ships and 1 ship loaded together.
    setterx = 1'b1;
    tick();
    setterx = 1'b0;
    check_eq("p7_clr", got7(), '0);
    check_eq("p1_clr", got1(), '0);
    tick();
    check_eq("p1_done", got1(), 64'd1);
    check_eq("p7_k1", got7(), exp_prefix(7, 1));
    repeat (5) tick();
    check_eq("p7_k6", got7(), exp_prefix(7, 6));
    tick();
    check_eq("p7_k7", got7(), exp_prefix(7, 7));
    repeat (5) tick();
    check_eq("p7_hold", got7(), exp_prefix(7, 7));
    check_eq("p1_hold", got1(), 64'd1);
    check_eq("p5_untouched", got5(), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
